// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, twiddle ROM region layout, mode encodings
// and the twiddle sequencer state encoding.
package kyber_pkg;
    localparam int N    = 128;
    localparam int LOGN = 7;
    localparam int Q    = 3329;

    localparam logic [8:0] W_BASE     = 9'd0;
    localparam logic [8:0] WINV_BASE  = 9'd127;
    localparam logic [8:0] WMULT_BASE = 9'd254;

    localparam logic [1:0] MODE_NTT  = 2'd0;
    localparam logic [1:0] MODE_INTT = 2'd1;
    localparam logic [1:0] MODE_MULT = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_FLUSH} state_e;
endpackage

// File: rtl/tw_addr_calc.sv
// tw_addr_calc: twiddle ROM address for (mode, layer, butterfly/index);
// purely combinational so the address formula can be tested on its own.
module tw_addr_calc
    import kyber_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [2:0] stage_i,
    input  logic [6:0] idx_i,
    output logic [8:0] addr_o
);
    logic [8:0] b, ntt_addr, intt_addr, mult_addr;

    always_comb begin
        b         = {3'd0, idx_i[5:0]};
        ntt_addr  = W_BASE + (9'd1 << stage_i) - 9'd1 + (b >> (3'(LOGN - 1) - stage_i));
        intt_addr = WINV_BASE + 9'(N) - (9'd1 << (3'(LOGN) - stage_i)) + (b >> stage_i);
        mult_addr = WMULT_BASE + {2'd0, idx_i};
        addr_o    = mode_i == MODE_NTT  ? ntt_addr :
                    mode_i == MODE_INTT ? intt_addr :
                    mode_i == MODE_MULT ? mult_addr : 9'd0;
    end
endmodule

// File: rtl/tw_addr_gen.sv
// tw_addr_gen: twiddle ROM address sequencer for NTT / INTT / pointwise multiply,
// with valid/last/stage tags aligned to the 1-cycle ROM read latency.
module tw_addr_gen
    import kyber_pkg::*;
#(
    parameter int STAGE_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       stall,
    output logic [8:0] raddr,
    output logic       tw_valid,
    output logic       tw_last,
    output logic [2:0] tw_stage,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0] GAP_LAST = 4'(STAGE_GAP - 1);

    state_e     state_q;
    logic [1:0] mode_q, mode_d;
    logic [2:0] s_q, s_d;
    logic [6:0] idx_q, idx_d;
    logic [3:0] gap_q;
    logic [8:0] raddr_q, addr_nxt;
    logic       tw_valid_q, tw_last_q, done_q;
    logic [2:0] tw_stage_q;
    logic       start_ok, accept, layer_end, op_end, adv, load;

    // Counters and address advance one step ahead so raddr is always the pending issue.
    always_comb begin
        start_ok  = state_q == ST_IDLE && start && mode != MODE_RSVD;
        accept    = state_q == ST_RUN && !stall;
        layer_end = mode_q != MODE_MULT && idx_q[5:0] == 6'd63;
        op_end    = mode_q == MODE_MULT ? idx_q == 7'd127 : layer_end && s_q == 3'(LOGN - 1);
        adv       = accept && !op_end;
        load      = start_ok || adv;
        mode_d    = start_ok ? mode : mode_q;
        s_d       = start_ok ? 3'd0 : adv && layer_end ? s_q + 3'd1 : s_q;
        idx_d     = start_ok ? 7'd0 : adv ? (layer_end ? 7'd0 : idx_q + 7'd1) : idx_q;
    end

    tw_addr_calc u_calc (
        .mode_i (mode_d),
        .stage_i(s_d),
        .idx_i  (idx_d),
        .addr_o (addr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_NTT;
            s_q        <= 3'd0;
            idx_q      <= 7'd0;
            gap_q      <= 4'd0;
            raddr_q    <= 9'd0;
            tw_valid_q <= 1'b0;
            tw_last_q  <= 1'b0;
            tw_stage_q <= 3'd0;
            done_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            s_q        <= s_d;
            idx_q      <= idx_d;
            tw_valid_q <= accept;
            tw_last_q  <= accept && op_end;
            done_q     <= accept && op_end;
            tw_stage_q <= s_q;
            if (load)
                raddr_q <= addr_nxt;
            case (state_q)
                ST_IDLE:
                    if (start_ok)
                        state_q <= ST_RUN;
                ST_RUN:
                    if (accept && op_end)
                        state_q <= ST_FLUSH;
                    else if (accept && layer_end && STAGE_GAP > 0) begin
                        state_q <= ST_GAP;
                        gap_q   <= 4'd0;
                    end
                ST_GAP:
                    if (gap_q == GAP_LAST)
                        state_q <= ST_RUN;
                    else
                        gap_q <= gap_q + 4'd1;
                ST_FLUSH:
                    state_q <= ST_IDLE;
                default:
                    state_q <= ST_IDLE;
            endcase
        end
    end

    assign raddr    = raddr_q;
    assign tw_valid = tw_valid_q;
    assign tw_last  = tw_last_q;
    assign tw_stage = tw_stage_q;
    assign done     = done_q;
    assign busy     = state_q != ST_IDLE;
endmodule

// File: tb/tb_tw_addr_gen.sv
// tb_tw_addr_gen: randomized-stall bench comparing delivered twiddle addresses,
// stage tags and completion timing against a loop-built reference order.
module tb_tw_addr_gen;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst, start, stall;
    logic [1:0] mode;
    logic [8:0] raddr;
    logic       tw_valid, tw_last, busy, done;
    logic [2:0] tw_stage;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_addr[$];
    int exp_stage[$];

    tw_addr_gen #(.STAGE_GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .stall   (stall),
        .raddr   (raddr),
        .tw_valid(tw_valid),
        .tw_last (tw_last),
        .tw_stage(tw_stage),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_valid"}, tw_valid, 0);
        check({tag, "_last"}, tw_last, 0);
        check({tag, "_stage"}, tw_stage, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Reference issue order: layer by layer, butterfly by butterfly.
    function automatic void build(input int m);
        exp_addr.delete();
        exp_stage.delete();
        if (m == 2) begin
            for (int i = 0; i < 128; i++) begin
                exp_addr.push_back(254 + i);
                exp_stage.push_back(0);
            end
        end else begin
            for (int s = 0; s < 7; s++)
                for (int b = 0; b < 64; b++) begin
                    exp_addr.push_back(m == 0 ? (2 ** s) - 1 + b / (2 ** (6 - s))
                                              : 255 - 2 ** (7 - s) + b / (2 ** s));
                    exp_stage.push_back(s);
                end
        end
    endfunction

    task automatic run_op(input int m, input int pct, input int st_lo, input int st_hi,
                          input bit spur, input int abort_at);
        int total, got, cyc, lat;
        logic [8:0] pa;
        logic ps;
        bit fin;
        build(m);
        total = exp_addr.size();
        lat   = total + (m == 2 ? 0 : 6 * GAP) + 1;
        mode  = 2'(m);
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc   = 1;
        got   = 0;
        fin   = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", tw_valid, 0);
        check("first_raddr", raddr, exp_addr[0]);
        while (!fin && cyc < 5000) begin
            ps    = (cyc >= st_lo && cyc <= st_hi) || ($urandom_range(99) < pct);
            stall = ps;
            if (spur && busy && $urandom_range(15) == 0) begin
                start = 1'b1;
                mode  = 2'($urandom_range(3));
            end
            pa = raddr;
            if (abort_at != 0 && cyc == abort_at) begin
                rst = 1'b1;
                tick;
                rst   = 1'b0;
                start = 1'b0;
                stall = 1'b0;
                check_zero("abort");
                for (int k = 0; k < 5; k++) begin
                    tick;
                    check("abort_no_done", done, 0);
                    check("abort_idle", busy, 0);
                end
                return;
            end
            tick;
            cyc++;
            start = 1'b0;
            if (tw_valid) begin
                if (exp_addr.size() == 0) begin
                    check("extra_valid", 1, 0);
                    fin = 1'b1;
                end else begin
                    check("addr", pa, exp_addr[0]);
                    check("stage", tw_stage, exp_stage[0]);
                    check("last", tw_last, exp_addr.size() == 1);
                    check("done", done, exp_addr.size() == 1);
                    void'(exp_addr.pop_front());
                    void'(exp_stage.pop_front());
                    got++;
                    fin = done || exp_addr.size() == 0;
                end
            end else begin
                check("done_without_valid", done, 0);
            end
            if (ps) begin
                check("stall_valid", tw_valid, 0);
                check("stall_hold", raddr, pa);
            end
        end
        stall = 1'b0;
        if (!fin)
            check("timeout", 0, 1);
        check("count", got, total);
        if (pct == 0 && st_lo > st_hi)
            check("latency", cyc, lat);
        tick;
        check("end_busy", busy, 0);
        check("end_valid", tw_valid, 0);
        check("end_done", done, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        mode  = 2'd0;
        repeat (3) tick;
        check_zero("reset");
        rst = 1'b0;
        tick;

        run_op(0, 0, 0, -1, 1'b0, 0);
        run_op(1, 0, 0, -1, 1'b0, 0);
        run_op(2, 0, 0, -1, 1'b0, 0);
        run_op(2, 0, 10, 12, 1'b0, 0);

        mode  = 2'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("rsvd_busy", busy, 0);
        check("rsvd_valid", tw_valid, 0);
        tick;
        check("rsvd_busy2", busy, 0);

        run_op(0, 30, 0, -1, 1'b1, 0);
        run_op(1, 30, 0, -1, 1'b1, 0);
        run_op(2, 50, 0, -1, 1'b1, 0);
        run_op(0, 0, 0, -1, 1'b1, 0);
        run_op(0, 0, 0, -1, 1'b0, 200);
        run_op(2, 0, 0, -1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tw_addr_gen.md
Name: tw_addr_gen

Overview:
- Twiddle-factor address sequencer for the Kyber polynomial multiplier.
- Drives the 9-bit read address of the 512x12 twiddle ROM (1-cycle read latency) in the order consumed by a single butterfly/basemul unit, for forward NTT, inverse NTT and pointwise multiplication.
- Emits a valid/last/stage tag aligned with ROM dout, so the downstream butterfly samples twiddle and tag in the same cycle.

Parameters:
- STAGE_GAP, 4, idle cycles inserted between NTT/INTT layers for butterfly pipeline drain; legal range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE with mode != 3
- mode  in  2  operation select: 0 NTT, 1 INTT, 2 MULT, 3 reserved
- stall  in  1  downstream back-pressure; freezes issue
- raddr  out  9  twiddle ROM read address (registered)
- tw_valid  out  1  ROM dout valid this cycle
- tw_last  out  1  with tw_valid: final twiddle of the operation
- tw_stage  out  3  layer index of the twiddle on dout (0 in MULT)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, coincident with tw_valid & tw_last

Behaviour:
- Reset: state IDLE; raddr=0, tw_valid=0, tw_last=0, tw_stage=0, busy=0, done=0; counters cleared. Reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE: on accepted start, latch mode, s=0, b=0, load raddr with the first address -> RUN.
  - RUN: presents raddr. Accept = RUN & ~stall. On accept, b increments and the next address is loaded. On the last accept of a layer (b=63 in NTT/INTT): go to GAP if STAGE_GAP>0, else continue RUN at the next layer. On the last accept of the operation -> FLUSH.
  - GAP: counts STAGE_GAP cycles, ignores stall, then -> RUN with s+1, b=0, raddr preloaded.
  - FLUSH: one cycle; tw_valid=tw_last=done=1 -> IDLE.
- Address rules (s = layer 0..6, b = butterfly 0..63, i = 0..127):
  - NTT: raddr = (2^s - 1) + (b >> (6-s)); range 0..126.
  - INTT: raddr = (255 - 2^(7-s)) + (b >> s); range 127..253.
  - MULT: raddr = 254 + i, single pass of 128 issues, no gaps; range 254..381.
- Output alignment:
  - tw_valid(t+1) = accept(t).
  - tw_stage(t+1) = s(t).
  - tw_last(t+1) = accept of final address at t.
- Stall:
  - raddr, s and b hold while stalled; stall in IDLE/GAP/FLUSH has no effect.
  - No address is skipped or duplicated.
- start while busy, or start with mode=3: ignored; no state change.
- Total accepts: NTT/INTT 448 over 7 layers; MULT 128. Unstalled NTT latency start->done = 448 + 6*STAGE_GAP + 1 cycles.
- All address arithmetic is 9-bit unsigned; shifts are logical.

Decomposition:
- Shared package kyber_pkg holds:
  - constants N=128, LOGN=7, Q=3329
  - ROM region bases W_BASE=0, WINV_BASE=127, WMULT_BASE=254
  - mode encodings MODE_NTT/MODE_INTT/MODE_MULT
  - FSM state enum
- One combinational sub-module, tw_addr_calc (mode, s, b/i -> 9-bit address), keeps the formula separately unit-testable.

Test Plan:
- NTT, STAGE_GAP=4, no stall, start at cycle 0:
  - raddr=0 for cycles 1..64; tw_valid cycles 2..65 with dout 0x6c1.
  - 4 bubble cycles, then raddr=1 x32, then 2 x32.
  - Final tw_valid has addr 126 (dout 0x86a) with tw_last=done=1 and tw_stage=6.
  - 448 valids total.
- INTT, no stall:
  - Layer 0 issues 127..190 once each; first dout 0x497.
  - Layer 6 issues 253 x64 (dout 0x640).
  - done coincides with the last valid.
- MULT, start at cycle 0:
  - raddr 254..381 on cycles 1..128; tw_valid cycles 2..129.
  - First dout 0x011; last dout 0x497 with tw_last=done=1 at cycle 129; busy low at cycle 130.
- MULT with stall high cycles 10..12:
  - raddr holds 263 during the stall.
  - tw_valid low cycles 11..13; 263 delivered at cycle 14.
  - 128 valids total, no duplicates.
- Ignored starts:
  - start with mode=3 -> busy stays 0.
  - start pulse during an NTT -> sequence unchanged.
- Reset mid-NTT (cycle 200):
  - Next cycle all outputs 0, no done pulse.
  - A subsequent MULT start completes normally.
